// File: rtl/sys_bus_resp_regs_if.sv
// sys_bus_resp_regs_if: request/ack system-bus bundle between a bus bridge
// (master side) and a register responder (slave side).
//   sys_addr  : byte address, word aligned (AW bits)
//   sys_wdata : write data
//   sys_wen   : write request, level or single-cycle strobe
//   sys_ren   : read request, level or single-cycle strobe
//   sys_rdata : read data returned by the responder
//   sys_ack   : one-cycle completion pulse
//   sys_err   : access error, meaningful only while sys_ack is high
interface sys_bus_resp_regs_if #(
  parameter int AW = 20
);
  logic [AW-1:0] sys_addr;
  logic [31:0]   sys_wdata;
  logic          sys_wen;
  logic          sys_ren;
  logic [31:0]   sys_rdata;
  logic          sys_ack;
  logic          sys_err;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_ack, sys_err
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_ack, sys_err
  );
endinterface

// File: rtl/sys_bus_resp_regs.sv
// sys_bus_resp_regs: register bank terminating the sys_bus request/ack
// protocol. One access at a time, programmable wait states, one-cycle ack.
//
// Ports:
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   bus      : sys_bus slave modport (addr/wdata/wen/ren in, rdata/ack/err out)
//   cfg_o    : config register contents, reg k at bits [32k+31:32k]
//   cfg_wr_o : one-cycle pulse per config register on a committed write
//
// Optional feature: define SYS_BUS_RESP_TSTAMP_EN to add a 64-bit
// free-running timestamp readable at 0x2C (low word) and 0x30 (high word
// shadow, captured when the low word is read).
//
// state | meaning
// IDLE  | waiting for sys_wen/sys_ren; captures the access
// WAIT  | counting ACK_DLY wait states, bus inputs ignored
// ACK   | sys_ack high for one cycle, then back to IDLE
module sys_bus_resp_regs #(
  parameter int          AW      = 20,
  parameter int          NREG    = 8,
  parameter int          ACK_DLY = 2,
  parameter logic [31:0] ID_VAL  = 32'h5253_0001
) (
  input  logic                 clk,
  input  logic                 rstn,
  sys_bus_resp_regs_if.slave   bus,
  output logic [NREG*32-1:0]   cfg_o,
  output logic [NREG-1:0]      cfg_wr_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int WAIT_LOAD = (ACK_DLY > 0) ? ACK_DLY - 1 : 0;

  state_t        state_q, state_d;
  logic [3:0]    wait_q;
  logic [AW-3:0] addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [31:0]   acc_cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   cfg_q [NREG];

  logic          req;
  logic          start;
  logic          commit;

  logic [AW-3:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_wr;
  logic [3:0]    word;
  logic          hi_zero;
  logic          hit_cfg;
  logic          hit_id;
  logic          hit_cnt;
  logic          hit_tlo;
  logic          hit_thi;
  logic          hit_ro;
  logic          unmapped;
  logic [31:0]   rd_val;

  logic [1:0]    unused_addr_lsb;

  assign unused_addr_lsb = bus.sys_addr[1:0];
  assign req = bus.sys_wen | bus.sys_ren;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // commit marks the edge that enters ACK: write, rdata and counter update there
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          start = 1'b1;
          if (ACK_DLY > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // With zero wait states the commit happens in IDLE, before the capture
  // registers are loaded, so decode from the live bus in that case.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr  = bus.sys_addr[AW-1:2];
      acc_wdata = bus.sys_wdata;
      acc_wr    = bus.sys_wen;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wr    = wr_q;
    end
  end

  assign word    = acc_addr[3:0];
  assign hi_zero = (acc_addr[AW-3:4] == '0);
  assign hit_cfg = hi_zero && ({28'd0, word} < 32'(NREG));
  assign hit_id  = hi_zero && (word == 4'd8);
  assign hit_cnt = hi_zero && (word == 4'd9);
`ifdef SYS_BUS_RESP_TSTAMP_EN
  assign hit_tlo = hi_zero && (word == 4'd11);
  assign hit_thi = hi_zero && (word == 4'd12);
`else
  assign hit_tlo = 1'b0;
  assign hit_thi = 1'b0;
`endif
  assign hit_ro   = hit_id | hit_cnt | hit_tlo | hit_thi;
  assign unmapped = !(hit_cfg | hit_ro);

`ifdef SYS_BUS_RESP_TSTAMP_EN
  logic [63:0] ts_q;
  logic [31:0] ts_hi_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q    <= '0;
      ts_hi_q <= '0;
    end else begin
      ts_q <= ts_q + 64'd1;
      // snapshot the high word with the low-word read so the pair is coherent
      if (commit && !acc_wr && hit_tlo) ts_hi_q <= ts_q[63:32];
    end
  end
`endif

  always_comb begin
    rd_val = 32'd0;
    for (int k = 0; k < NREG; k++) begin
      if (hit_cfg && (word == 4'(k))) rd_val = cfg_q[k];
    end
    if (hit_id)  rd_val = ID_VAL;
    if (hit_cnt) rd_val = acc_cnt_q;
`ifdef SYS_BUS_RESP_TSTAMP_EN
    if (hit_tlo) rd_val = ts_q[31:0];
    if (hit_thi) rd_val = ts_hi_q;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      acc_cnt_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cfg_wr_o  <= '0;
      for (int k = 0; k < NREG; k++) cfg_q[k] <= '0;
    end else begin
      cfg_wr_o <= '0;
      if (start) begin
        addr_q  <= bus.sys_addr[AW-1:2];
        wdata_q <= bus.sys_wdata;
        wr_q    <= bus.sys_wen;
      end
      if (state_q == ST_IDLE && state_d == ST_WAIT) begin
        wait_q <= WAIT_LOAD[3:0];
      end else if (state_q == ST_WAIT && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (commit) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
        err_q     <= unmapped;
        if (acc_wr) begin
          for (int k = 0; k < NREG; k++) begin
            if (hit_cfg && (word == 4'(k))) begin
              cfg_q[k]    <= acc_wdata;
              cfg_wr_o[k] <= 1'b1;
            end
          end
        end else begin
          rdata_q <= rd_val;
        end
      end
    end
  end

  always_comb begin
    cfg_o = '0;
    for (int k = 0; k < NREG; k++) cfg_o[32*k +: 32] = cfg_q[k];
  end

  assign bus.sys_ack   = (state_q == ST_ACK);
  assign bus.sys_err   = (state_q == ST_ACK) && err_q;
  assign bus.sys_rdata = rdata_q;

endmodule

// File: tb/tb_sys_bus_resp_regs.sv
module tb_sys_bus_resp_regs;
  localparam int AW      = 20;
  localparam int NREG    = 4;
  localparam int ACK_DLY = 2;
  localparam logic [31:0] ID = 32'h5253_0001;

  logic clk;
  logic rstn;
  logic [NREG*32-1:0] cfg_o;
  logic [NREG-1:0]    cfg_wr_o;

  sys_bus_resp_regs_if #(.AW(AW)) bus ();

  sys_bus_resp_regs #(
    .AW(AW), .NREG(NREG), .ACK_DLY(ACK_DLY), .ID_VAL(ID)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .cfg_o(cfg_o), .cfg_wr_o(cfg_wr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_cfg [NREG];
  logic [31:0] m_cnt;
  logic [31:0] m_rdata;
  logic [31:0] m_shadow;
  logic [63:0] ts_m;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) ts_m <= 64'd0;
    else       ts_m <= ts_m + 64'd1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREG*32-1:0] exp_cfg();
    logic [NREG*32-1:0] v;
    for (int k = 0; k < NREG; k++) v[32*k +: 32] = m_cfg[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_cfg[k] = 32'd0;
    m_cnt    = 32'd0;
    m_rdata  = 32'd0;
    m_shadow = 32'd0;
  endtask

  // One access. level=1 holds the request until ack, level=0 is a one-cycle
  // strobe followed by junk on addr/wdata, which the responder must ignore.
  task automatic do_acc(input bit w, input bit r, input logic [AW-1:0] a,
                        input logic [31:0] d, input bit level);
    int n;
    bit got;
    int idx;
    bit hi0, is_cfg, is_ro, err_e;
    logic [NREG-1:0] wr_e;
    logic [63:0] t;
    @(negedge clk);
    bus.sys_wen   = w;
    bus.sys_ren   = r;
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (!level && n == 1) begin
        bus.sys_wen   = 1'b0;
        bus.sys_ren   = 1'b0;
        bus.sys_addr  = AW'($urandom);
        bus.sys_wdata = $urandom;
      end
      if (bus.sys_ack) got = 1'b1;
    end
    bus.sys_wen = 1'b0;
    bus.sys_ren = 1'b0;

    idx    = int'(a[5:2]);
    hi0    = (a[AW-1:6] == '0);
    is_cfg = hi0 && (idx < NREG);
    is_ro  = hi0 && (idx == 8 || idx == 9);
`ifdef SYS_BUS_RESP_TSTAMP_EN
    is_ro  = is_ro || (hi0 && (idx == 11 || idx == 12));
`endif
    err_e = !(is_cfg || is_ro);
    wr_e  = '0;
    if (w) begin
      if (is_cfg) begin
        m_cfg[idx] = d;
        wr_e[idx]  = 1'b1;
      end
    end else begin
      m_rdata = 32'd0;
      if (is_cfg)                 m_rdata = m_cfg[idx];
      else if (hi0 && idx == 8)   m_rdata = ID;
      else if (hi0 && idx == 9)   m_rdata = m_cnt;
`ifdef SYS_BUS_RESP_TSTAMP_EN
      else if (hi0 && idx == 11) begin
        t = ts_m - 64'd1;
        m_rdata  = t[31:0];
        m_shadow = t[63:32];
      end
      else if (hi0 && idx == 12)  m_rdata = m_shadow;
`endif
    end
    m_cnt = m_cnt + 32'd1;

    chk("ack_seen", 256'(got), 256'(1'b1));
    chk("latency", 256'(n), 256'(1 + ACK_DLY));
    chk("err", 256'(bus.sys_err), 256'(err_e));
    chk("rdata", 256'(bus.sys_rdata), 256'(m_rdata));
    chk("cfg_o", 256'(cfg_o), 256'(exp_cfg()));
    chk("cfg_wr", 256'(cfg_wr_o), 256'(wr_e));
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 256'(bus.sys_ack), 256'(1'b0));
    chk("cfg_wr_clear", 256'(cfg_wr_o), 256'(0));
  endtask

  initial begin
    logic [AW-1:0] a;
    int sel;
    rstn = 1'b0;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;
    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    model_reset();
    #12;
    chk("rst_ack", 256'(bus.sys_ack), 256'(0));
    chk("rst_err", 256'(bus.sys_err), 256'(0));
    chk("rst_rdata", 256'(bus.sys_rdata), 256'(0));
    chk("rst_cfg", 256'(cfg_o), 256'(0));
    chk("rst_cfg_wr", 256'(cfg_wr_o), 256'(0));
    @(negedge clk);
    rstn = 1'b1;

    do_acc(1'b1, 1'b0, 20'h00004, 32'hCAFE_BABE, 1'b1);
    do_acc(1'b0, 1'b1, 20'h00020, 32'd0, 1'b0);
    do_acc(1'b0, 1'b1, 20'h00024, 32'd0, 1'b0);
    do_acc(1'b1, 1'b1, 20'h00008, 32'h11, 1'b1);
    do_acc(1'b0, 1'b1, 20'h00008, 32'd0, 1'b0);
    do_acc(1'b0, 1'b1, 20'h00014, 32'd0, 1'b1);
    do_acc(1'b0, 1'b1, 20'h01000, 32'd0, 1'b0);
    do_acc(1'b1, 1'b0, 20'h00024, 32'hFFFF_0000, 1'b0);
    do_acc(1'b0, 1'b1, 20'h00024, 32'd0, 1'b1);
    do_acc(1'b0, 1'b1, 20'h0002C, 32'd0, 1'b0);
    do_acc(1'b0, 1'b1, 20'h00030, 32'd0, 1'b0);
    do_acc(1'b1, 1'b0, 20'h0002C, 32'h1234, 1'b0);
    do_acc(1'b0, 1'b1, 20'h00028, 32'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = a | AW'($urandom_range(1, (1 << (AW - 6)) - 1) << 6);
      sel = $urandom_range(0, 2);
      do_acc(sel != 1, sel != 0, a, $urandom, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // reset while a write to 0x00 is waiting
    @(negedge clk);
    bus.sys_wen   = 1'b1;
    bus.sys_addr  = '0;
    bus.sys_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.sys_wen = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_ack", 256'(bus.sys_ack), 256'(0));
      chk("rst_mid_cfg", 256'(cfg_o), 256'(0));
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_ack", 256'(bus.sys_ack), 256'(0));
    end
    chk("post_rst_rdata", 256'(bus.sys_rdata), 256'(0));
    do_acc(1'b0, 1'b1, 20'h00024, 32'd0, 1'b0);
    do_acc(1'b0, 1'b1, 20'h0002C, 32'd0, 1'b1);
    do_acc(1'b0, 1'b1, 20'h00030, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
